// File: rtl/keypad_scan_fsm_pkg.sv
// keypad_pkg: shared constants, FSM state encoding and helpers for the 3x3 keypad scanner.
//   NUM_ROWS/NUM_COLS : keypad geometry
//   KEY_W             : width of a key index (0..8)
//   scan_state_e      : scanner FSM states
//   onehot9_to_index  : position of the set bit in a key map
//   is_onehot9        : true when exactly one key bit is set
//   col_drive         : active-low column pattern for a column number
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 3;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int unsigned KEY_W    = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StEval = 2'd2
    } scan_state_e;

    function automatic logic [KEY_W-1:0] onehot9_to_index(input logic [NUM_KEYS-1:0] map);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (map[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot9(input logic [NUM_KEYS-1:0] map);
        return (map != '0) && ((map & (map - NUM_KEYS'(1))) == '0);
    endfunction

    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
        return ~(NUM_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/keypad_scan_fsm_if.sv
// keypad_scan_fsm_if: key-event channel from the scanner to the game logic.
//   key       : index of the pressed key, 3*row+col
//   key_valid : an event is held in the output register
//   key_ready : consumer accepts the event when key_valid & key_ready
//   overflow  : sticky flag, an event was dropped
// master = scanner (event source), slave = consumer.
interface keypad_scan_fsm_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             key_ready;
    logic             overflow;

    modport master (output key, output key_valid, output overflow, input key_ready);
    modport slave  (input key, input key_valid, input overflow, output key_ready);

endinterface

// File: rtl/keypad_scan_fsm_scan_tick_gen.sv
// scan_tick_gen: divides clk down to the column scan tick.
//   i_clk    : system clock
//   i_reset  : asynchronous active-low reset
//   i_enable : count while high, counter held at 0 while low
//   o_tick   : one-clk pulse on the last count of each TICK_DIV period
module scan_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(TICK_DIV - 1));
    assign o_tick = i_enable & w_last;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (!i_enable || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: 3x3 keypad scanner, debouncer and key-event source.
//   i_clk    : system clock
//   i_reset  : asynchronous active-low reset
//   i_enable : scanning enabled
//   i_row    : keypad rows, active-low, asynchronous to clk
//   o_column : column drive, active-low, 3'b111 = none driven
//   evt      : key event channel (key, key_valid, key_ready, overflow)
module keypad_scan_fsm import keypad_pkg::*; #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NUM_ROWS-1:0] i_row,
    output logic [NUM_COLS-1:0] o_column,
    keypad_scan_fsm_if.master   evt
);

    localparam int unsigned STB_W = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [STB_W-1:0] STABLE_MAX = STB_W'(DEBOUNCE_SCANS - 1);

    logic [NUM_ROWS-1:0] r_row_meta;
    logic [NUM_ROWS-1:0] r_row_sync;
    scan_state_e         r_state;
    logic [1:0]          r_col;
    logic [NUM_COLS-1:0] r_column;
    logic [NUM_KEYS-1:0] r_raw;
    logic [NUM_KEYS-1:0] r_prev_raw;
    logic [NUM_KEYS-1:0] r_debounced;
    logic [STB_W-1:0]    r_stable_cnt;
    logic [KEY_W-1:0]    r_key;
    logic                r_key_valid;
    logic                r_overflow;

    logic                w_tick;
    logic [NUM_KEYS-1:0] w_raw_next;
    logic [STB_W-1:0]    w_stable_nxt;
    logic                w_deb_upd;
    logic                w_event;
    logic [KEY_W-1:0]    w_event_idx;

    // Counter is held in IDLE so the first column after enabling gets a full tick.
    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable && (r_state != StIdle)),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
        end
    end

    // Rows are active-low: a low row on the driven column marks a pressed key.
    always_comb begin
        w_raw_next = r_raw;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (c == 32'(r_col)) w_raw_next[r*NUM_COLS + c] = ~r_row_sync[r];
            end
        end
    end

    always_comb begin
        w_stable_nxt = '0;
        if (r_raw == r_prev_raw) begin
            w_stable_nxt = (r_stable_cnt == STABLE_MAX) ? STABLE_MAX
                                                        : r_stable_cnt + STB_W'(1);
        end
    end

    assign w_deb_upd   = (w_stable_nxt == STABLE_MAX);
    // New single key only: ghosted multi-key maps and keys already down never fire.
    assign w_event     = (r_state == StEval) && i_enable && w_deb_upd && is_onehot9(r_raw)
                         && ((r_raw & r_debounced) == '0);
    assign w_event_idx = onehot9_to_index(r_raw);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_col        <= '0;
            r_column     <= '1;
            r_raw        <= '0;
            r_prev_raw   <= '0;
            r_debounced  <= '0;
            r_stable_cnt <= '0;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // One-deep holding register; a full, un-accepted slot drops the new event.
            if (w_event) begin
                if (!r_key_valid || evt.key_ready) begin
                    r_key       <= w_event_idx;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overflow  <= 1'b1;
                end
            end else if (r_key_valid && evt.key_ready) begin
                r_key_valid <= 1'b0;
            end

            if (!i_enable) begin
                // Debounced map survives a pause; the partial frame does not.
                r_state      <= StIdle;
                r_col        <= '0;
                r_column     <= '1;
                r_raw        <= '0;
                r_stable_cnt <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state  <= StScan;
                        r_col    <= '0;
                        r_column <= col_drive(2'd0);
                    end
                    StScan: begin
                        if (w_tick) begin
                            r_raw <= w_raw_next;
                            if (r_col == 2'(NUM_COLS - 1)) begin
                                r_state  <= StEval;
                                r_column <= '1;
                            end else begin
                                r_col    <= r_col + 2'd1;
                                r_column <= col_drive(r_col + 2'd1);
                            end
                        end
                    end
                    StEval: begin
                        r_prev_raw   <= r_raw;
                        r_stable_cnt <= w_stable_nxt;
                        if (w_deb_upd) r_debounced <= r_raw;
                        r_state  <= StScan;
                        r_col    <= '0;
                        r_column <= col_drive(2'd0);
                    end
                    default: begin
                        r_state  <= StIdle;
                        r_column <= '1;
                    end
                endcase
            end
        end
    end

    assign o_column      = r_column;
    assign evt.key       = r_key;
    assign evt.key_valid = r_key_valid;
    assign evt.overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Bench for keypad_scan_fsm with TICK_DIV=4, DEBOUNCE_SCANS=3 and a behavioural keypad.
module tb_keypad_scan_fsm;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] row;
    logic [2:0] column;
    logic [8:0] pressed;

    int n_checks = 0;
    int n_errors = 0;
    int n_evt    = 0;
    int mon_exp;
    int exp_q[$];

    int         seg_len[8] = '{4, 4, 4, 1, 3, 4, 4, 1};
    logic [2:0] seg_val[8] = '{3'b110, 3'b101, 3'b011, 3'b111,
                               3'b110, 3'b101, 3'b011, 3'b111};
    logic [2:0] exp_cols[$];

    keypad_scan_fsm_if evt_if ();

    keypad_scan_fsm #(
        .TICK_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_enable (enable),
        .i_row    (row),
        .o_column (column),
        .evt      (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a held key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 3'b111;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3 + c] && !column[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every accepted event must match the oldest expected key; 15 marks an unexpected event.
    always @(negedge clk) begin
        if (rst_n && evt_if.key_valid && evt_if.key_ready) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 15;
            n_evt++;
            check_eq("evt_key", 32'(evt_if.key), 32'(mon_exp));
        end
    end

    // Returns at the negedge inside the n-th following EVAL cycle.
    task automatic wait_eval(input int n);
        for (int k = 0; k < n; k++) begin
            int budget;
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (column !== 3'b111 && budget < 40);
            if (column !== 3'b111) check_eq("eval_timeout", 32'(column), 32'd7);
        end
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 evt_if.key_ready = 1'b1;
        @(posedge clk);
        #1 evt_if.key_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        pressed = '0;
        evt_if.key_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < seg_len[s]; j++) exp_cols.push_back(seg_val[s]);
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_column", 32'(column), 32'd7);
        check_eq("rst_valid", 32'(evt_if.key_valid), 32'd0);
        check_eq("rst_key", 32'(evt_if.key), 32'd0);
        check_eq("rst_overflow", 32'(evt_if.overflow), 32'd0);

        // Scan order: the counter keeps running through EVAL, so later col0 slots are 3 clk
        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        for (int i = 0; i < exp_cols.size(); i++) begin
            @(negedge clk);
            check_eq($sformatf("scan_col%0d", i), 32'(column), 32'(exp_cols[i]));
        end
        check_eq("scan_no_valid", 32'(evt_if.key_valid), 32'd0);

        // Asynchronous reset in the middle of a column slot
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_async_col", 32'(column), 32'd7);
        check_eq("rst_async_valid", 32'(evt_if.key_valid), 32'd0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_idle_col", 32'(column), 32'd7);
        check_eq("rst_idle_valid", 32'(evt_if.key_valid), 32'd0);
        @(posedge clk);
        #1 enable = 1'b1;
        evt_if.key_ready = 1'b0;

        // Single press of key (1,2): event 1 clk after the 3rd identical EVAL
        wait_eval(1);
        pressed[5] = 1'b1;
        exp_q.push_back(5);
        wait_eval(3);
        check_eq("press_pre", 32'(evt_if.key_valid), 32'd0);
        @(negedge clk);
        check_eq("press_valid", 32'(evt_if.key_valid), 32'd1);
        check_eq("press_key", 32'(evt_if.key), 32'd5);
        repeat (10) @(negedge clk);
        check_eq("press_hold", 32'(evt_if.key_valid), 32'd1);
        pulse_ready();
        @(negedge clk);
        check_eq("press_drop", 32'(evt_if.key_valid), 32'd0);
        check_eq("press_cnt", 32'(n_evt), 32'd1);

        // Release, then re-press the same key
        pressed = '0;
        wait_eval(4);
        evt_if.key_ready = 1'b1;
        pressed[5] = 1'b1;
        exp_q.push_back(5);
        wait_eval(3);
        repeat (2) @(negedge clk);
        check_eq("repress_cnt", 32'(n_evt), 32'd2);

        // Ghost: keys 0 and 8 together give no event
        pressed = 9'h101;
        wait_eval(4);
        check_eq("ghost_none", 32'(n_evt), 32'd2);
        // Key 8 is already in the debounced map, so dropping key 0 is not a new press
        pressed = 9'h100;
        wait_eval(4);
        check_eq("ghost_rel0", 32'(n_evt), 32'd2);
        pressed = '0;
        wait_eval(4);
        pressed = 9'h100;
        exp_q.push_back(8);
        wait_eval(3);
        repeat (2) @(negedge clk);
        check_eq("ghost_key8", 32'(n_evt), 32'd3);

        // Bounce: key 3 toggling every frame never settles
        pressed = '0;
        wait_eval(4);
        for (int i = 0; i < 6; i++) begin
            pressed[3] = (i % 2 == 0);
            wait_eval(1);
        end
        check_eq("bounce_none", 32'(n_evt), 32'd3);
        pressed[3] = 1'b1;
        exp_q.push_back(3);
        wait_eval(3);
        repeat (2) @(negedge clk);
        check_eq("bounce_key3", 32'(n_evt), 32'd4);

        // Overflow: second event while the first is still held
        pressed = '0;
        wait_eval(4);
        @(posedge clk);
        #1 evt_if.key_ready = 1'b0;
        wait_eval(1);
        pressed[1] = 1'b1;
        exp_q.push_back(1);
        wait_eval(3);
        @(negedge clk);
        check_eq("ovf_first_valid", 32'(evt_if.key_valid), 32'd1);
        check_eq("ovf_first_key", 32'(evt_if.key), 32'd1);
        check_eq("ovf_pre_flag", 32'(evt_if.overflow), 32'd0);
        pressed = '0;
        wait_eval(4);
        pressed[7] = 1'b1;
        wait_eval(3);
        repeat (2) @(negedge clk);
        check_eq("ovf_key", 32'(evt_if.key), 32'd1);
        check_eq("ovf_flag", 32'(evt_if.overflow), 32'd1);
        check_eq("ovf_valid", 32'(evt_if.key_valid), 32'd1);
        pulse_ready();
        @(negedge clk);
        check_eq("ovf_drop_valid", 32'(evt_if.key_valid), 32'd0);
        check_eq("ovf_sticky", 32'(evt_if.overflow), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("ovf_rst", 32'(evt_if.overflow), 32'd0);
        #3 rst_n = 1'b1;

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("evt_total", 32'(n_evt), 32'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
